// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between ID decode and the EX-stage forwarding/hazard control.
// master: ID-side driver (decode fields, hold, flush); receives stall and
//         the registered forwarding selects.
// slave:  fwd_hazard_ctrl side.
//   hold, flush, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
//   id_rd, id_regwrite, id_memread              : master -> slave
//   stall, fwd_sel_a, fwd_sel_b, ex_valid, stall_count : slave -> master
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              stall;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              ex_valid;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_regwrite, id_memread,
    input  stall, fwd_sel_a, fwd_sel_b, ex_valid, stall_count
  );

  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_regwrite, id_memread,
    output stall, fwd_sel_a, fwd_sel_b, ex_valid, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Control for the EX-stage 3:1 operand forwarding muxes of the 5-stage pipeline.
// Tracks destination registers of the instructions in EX and MEM, registers
// the rs1/rs2 mux selects into EX, and detects load-use hazards (one stall
// cycle plus an EX bubble).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - fwd_hazard_ctrl_if.slave: ID decode info, hold/flush in;
//           stall (combinational), fwd_sel_a/b, ex_valid, stall_count out
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  fwd_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_MEMWB = 2'b01,
    SEL_EXMEM = 2'b10
  } fwdSel_t;

  logic              exValid, exRegWrite, exMemRead;
  logic [REG_AW-1:0] exRd;
  logic              memValid, memRegWrite;
  logic [REG_AW-1:0] memRd;
  fwdSel_t           selA, selB;
  fwdSel_t           selANext, selBNext;
  logic [CNT_W-1:0]  stallCnt;
  logic              stall, bubble;
  logic              exFwdOk, memFwdOk;

  // A producer is forwardable only if it is real, writes, and targets non-x0.
  assign exFwdOk  = exValid  & exRegWrite  & (exRd  != '0);
  assign memFwdOk = memValid & memRegWrite & (memRd != '0);

  assign stall = bus.id_valid & ~bus.flush & exValid & exMemRead & (exRd != '0) &
                 ((bus.id_uses_rs1 & (bus.id_rs1 == exRd)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == exRd)));

  assign bubble = stall | bus.flush;

  // EX/MEM match checked first so the newest producer wins.
  always_comb begin
    selANext = SEL_RF;
    selBNext = SEL_RF;
    if (bus.id_uses_rs1 & exFwdOk & (bus.id_rs1 == exRd))
      selANext = SEL_EXMEM;
    else if (bus.id_uses_rs1 & memFwdOk & (bus.id_rs1 == memRd))
      selANext = SEL_MEMWB;
    if (bus.id_uses_rs2 & exFwdOk & (bus.id_rs2 == exRd))
      selBNext = SEL_EXMEM;
    else if (bus.id_uses_rs2 & memFwdOk & (bus.id_rs2 == memRd))
      selBNext = SEL_MEMWB;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exValid     <= 1'b0;
      exRegWrite  <= 1'b0;
      exMemRead   <= 1'b0;
      exRd        <= '0;
      memValid    <= 1'b0;
      memRegWrite <= 1'b0;
      memRd       <= '0;
      selA        <= SEL_RF;
      selB        <= SEL_RF;
      stallCnt    <= '0;
    end else if (!bus.hold) begin
      memValid    <= exValid;
      memRegWrite <= exRegWrite;
      memRd       <= exRd;
      if (bubble) begin
        exValid    <= 1'b0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
        exRd       <= '0;
        selA       <= SEL_RF;
        selB       <= SEL_RF;
      end else begin
        exValid    <= bus.id_valid;
        exRegWrite <= bus.id_regwrite;
        exMemRead  <= bus.id_memread;
        exRd       <= bus.id_rd;
        selA       <= selANext;
        selB       <= selBNext;
      end
      if (stall && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_sel_a   = selA;
  assign bus.fwd_sel_b   = selB;
  assign bus.ex_valid    = exValid;
  assign bus.stall_count = stallCnt;

endmodule
